// File: rtl/rom_arbiter_if.sv
// Request/response and ROM-macro signals shared between the arbiter, its clients and the ROM.
// The slave modport is the arbiter's view of these signals.
interface rom_arbiter_if #(
    parameter int unsigned nreq  = 2,
    parameter int unsigned abits = 17,
    parameter int unsigned dbits = 64
);
    logic [nreq-1:0]       i_req_valid;
    logic [nreq*abits-1:0] i_req_addr;
    logic [nreq-1:0]       o_req_ready;
    logic [nreq-1:0]       o_resp_valid;
    logic [dbits-1:0]      o_resp_rdata;
    logic [nreq-1:0]       i_resp_ready;
    logic [abits-1:0]      o_rom_addr;
    logic [dbits-1:0]      i_rom_rdata;
    logic                  o_busy;

    modport slave (
        input  i_req_valid,
        input  i_req_addr,
        output o_req_ready,
        output o_resp_valid,
        output o_resp_rdata,
        input  i_resp_ready,
        output o_rom_addr,
        input  i_rom_rdata,
        output o_busy
    );

    modport master (
        output i_req_valid,
        output i_req_addr,
        input  o_req_ready,
        input  o_resp_valid,
        input  o_resp_rdata,
        output i_resp_ready,
        input  o_rom_addr,
        output i_rom_rdata,
        input  o_busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-address ROM macro among nreq readers.
// Two-stage pipeline: stage 1 holds the issued read, stage 2 holds the returned word.
module rom_arbiter #(
    parameter int unsigned nreq  = 2,
    parameter int unsigned abits = 17,
    parameter int unsigned dbits = 64
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    rom_arbiter_if.slave bus
);
    localparam int unsigned LW = (nreq > 1) ? $clog2(nreq) : 1;

    logic [LW-1:0]    r_last;
    logic             r_rd_valid;
    logic [LW-1:0]    r_rd_owner;
    logic [abits-1:0] r_rd_addr;
    logic             r_resp_valid;
    logic [LW-1:0]    r_resp_owner;
    logic [dbits-1:0] r_resp_rdata;

    logic [LW-1:0]    last_n;
    logic             rd_valid_n;
    logic [LW-1:0]    rd_owner_n;
    logic [abits-1:0] rd_addr_n;
    logic             resp_valid_n;
    logic [LW-1:0]    resp_owner_n;
    logic [dbits-1:0] resp_rdata_n;

    logic             resp_hs;
    logic             s1_move;
    logic             can_accept;
    logic             any_req;
    logic             accept;
    logic [LW-1:0]    grant;
    int unsigned      idx;
    logic [abits-1:0] addr_a [nreq];

    for (genvar k = 0; k < nreq; k++) begin : g_unpack
        assign addr_a[k] = bus.i_req_addr[k*abits +: abits];
    end

    // Pipeline advance conditions
    assign resp_hs    = r_resp_valid && bus.i_resp_ready[r_resp_owner];
    assign s1_move    = r_rd_valid && (!r_resp_valid || resp_hs);
    assign can_accept = !r_rd_valid || s1_move;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= nreq; i++) begin
            idx = (32'(r_last) + i) % nreq;
            if (!any_req && bus.i_req_valid[LW'(idx)]) begin
                any_req = 1'b1;
                grant   = LW'(idx);
            end
        end
    end

    // Gated by reset so the combinational outputs drop without waiting for a clock
    assign accept = i_nrst && can_accept && any_req;

    always_comb begin
        bus.o_req_ready = '0;
        if (accept) begin
            bus.o_req_ready[grant] = 1'b1;
        end
    end

    // Re-present the stage-1 address while stalled so the ROM output stays valid
    assign bus.o_rom_addr = accept ? addr_a[grant] : r_rd_addr;

    for (genvar k = 0; k < nreq; k++) begin : g_resp_valid
        assign bus.o_resp_valid[k] = r_resp_valid && (r_resp_owner == LW'(k));
    end

    assign bus.o_resp_rdata = r_resp_rdata;
    assign bus.o_busy       = r_rd_valid || r_resp_valid;

    // Next-state logic for both pipeline stages and the arbitration pointer
    always_comb begin
        last_n       = r_last;
        rd_valid_n   = r_rd_valid;
        rd_owner_n   = r_rd_owner;
        rd_addr_n    = r_rd_addr;
        resp_valid_n = r_resp_valid;
        resp_owner_n = r_resp_owner;
        resp_rdata_n = r_resp_rdata;

        if (accept) begin
            last_n     = grant;
            rd_valid_n = 1'b1;
            rd_owner_n = grant;
            rd_addr_n  = addr_a[grant];
        end else if (s1_move) begin
            rd_valid_n = 1'b0;
        end

        if (s1_move) begin
            resp_valid_n = 1'b1;
            resp_owner_n = r_rd_owner;
            resp_rdata_n = bus.i_rom_rdata;
        end else if (resp_hs) begin
            resp_valid_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_last       <= LW'(nreq - 1);
            r_rd_valid   <= 1'b0;
            r_rd_owner   <= '0;
            r_rd_addr    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_owner <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_last       <= last_n;
            r_rd_valid   <= rd_valid_n;
            r_rd_owner   <= rd_owner_n;
            r_rd_addr    <= rd_addr_n;
            r_resp_valid <= resp_valid_n;
            r_resp_owner <= resp_owner_n;
            r_resp_rdata <= resp_rdata_n;
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic, checked against an
// in-order transaction-queue model of the arbiter with a behavioural ROM.
module tb_rom_arbiter;
    localparam int NREQ  = 3;
    localparam int ABITS = 17;
    localparam int DBITS = 64;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    rom_arbiter_if #(.nreq(NREQ), .abits(ABITS), .dbits(DBITS)) bus ();
    rom_arbiter #(.nreq(NREQ), .abits(ABITS), .dbits(DBITS)) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .bus   (bus)
    );

    logic [NREQ-1:0]  valid;
    logic [NREQ-1:0]  rready;
    logic [ABITS-1:0] addr [NREQ];

    assign bus.i_req_valid  = valid;
    assign bus.i_resp_ready = rready;
    for (genvar k = 0; k < NREQ; k++) begin : g_addr
        assign bus.i_req_addr[k*ABITS +: ABITS] = addr[k];
    end

    function automatic logic [DBITS-1:0] rom_word(input logic [ABITS-1:0] a);
        return {16'hA5A5, 31'h0, a};
    endfunction

    // Behavioural ROM macro: registered address, data one cycle later
    always @(posedge clk) bus.i_rom_rdata <= rom_word(bus.o_rom_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int               owner;
        logic [DBITS-1:0] data;
        int               cyc;
    } item_t;

    item_t            q[$];
    int               m_last = NREQ - 1;
    logic [ABITS-1:0] m_last_addr = '0;
    int               cyc = 0;
    bit               vis, hs, acc;
    int               g;
    logic [NREQ-1:0]  exp_rv, exp_ready;
    logic [ABITS-1:0] exp_addr;

    // Reference model: reads complete in accept order; at most two in flight, a third
    // only when the oldest is handed over the same cycle; a read is visible 2 cycles on.
    always @(negedge clk) begin
        if (!nrst) begin
            q.delete();
            m_last      = NREQ - 1;
            m_last_addr = '0;
            chk("rst_req_ready", 64'(bus.o_req_ready), 64'h0);
            chk("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
            chk("rst_resp_rdata", bus.o_resp_rdata, 64'h0);
            chk("rst_rom_addr", 64'(bus.o_rom_addr), 64'h0);
            chk("rst_busy", 64'(bus.o_busy), 64'h0);
        end else begin
            cyc++;
            vis    = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            hs     = vis && rready[q[0].owner];
            exp_rv = '0;
            if (vis) exp_rv[q[0].owner] = 1'b1;
            g = -1;
            for (int i = 1; i <= NREQ; i++) begin
                if (g < 0 && valid[(m_last + i) % NREQ]) g = (m_last + i) % NREQ;
            end
            acc       = (g >= 0) && ((q.size() < 2) || hs);
            exp_ready = '0;
            if (acc) exp_ready[g] = 1'b1;
            exp_addr = acc ? addr[g] : m_last_addr;

            chk("req_ready", 64'(bus.o_req_ready), 64'(exp_ready));
            chk("resp_valid", 64'(bus.o_resp_valid), 64'(exp_rv));
            chk("busy", 64'(bus.o_busy), 64'(q.size() != 0));
            chk("rom_addr", 64'(bus.o_rom_addr), 64'(exp_addr));
            if (vis) chk("resp_rdata", bus.o_resp_rdata, q[0].data);

            if (hs) void'(q.pop_front());
            if (acc) begin
                q.push_back('{owner: g, data: rom_word(addr[g]), cyc: cyc});
                m_last      = g;
                m_last_addr = addr[g];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        nrst  = 1'b0;
        valid = '0;
        rready = '1;
        tick();
        nrst = 1'b1;
    endtask

    int nacc;
    bit hsk;

    initial begin
        nrst   = 1'b0;
        valid  = '0;
        rready = '1;
        for (int k = 0; k < NREQ; k++) addr[k] = '0;
        tick();
        tick();
        nrst = 1'b1;

        // Single read with exact latency
        valid   = 3'b001;
        addr[0] = 17'h10;
        tick();
        valid = '0;
        chk("single_busy_s1", 64'(bus.o_busy), 64'h1);
        tick();
        chk("single_resp_valid", 64'(bus.o_resp_valid), 64'h1);
        chk("single_data", bus.o_resp_rdata, 64'hA5A5_0000_0000_0010);
        chk("single_busy_s2", 64'(bus.o_busy), 64'h1);
        tick();
        chk("single_idle", 64'(bus.o_busy), 64'h0);

        // Round-robin with all requesters active
        do_reset();
        valid   = 3'b111;
        addr[0] = 17'h1;
        addr[1] = 17'h2;
        addr[2] = 17'h3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_grant", 64'(bus.o_req_ready), 64'(3'b001 << (i % 3)));
        end
        tick();
        valid = '0;
        repeat (4) tick();

        // Backpressure on requester 0
        do_reset();
        rready[0] = 1'b0;
        valid     = 3'b001;
        addr[0]   = '0;
        nacc      = 0;
        repeat (5) begin
            @(negedge clk);
            hsk = bus.o_req_ready[0] && valid[0];
            if (hsk) nacc++;
            tick();
            if (hsk) addr[0]++;
        end
        chk("bp_accepts", 64'(nacc), 64'h2);
        chk("bp_rom_addr_hold", 64'(bus.o_rom_addr), 64'h1);
        chk("bp_ready_low", 64'(bus.o_req_ready), 64'h0);
        rready[0] = 1'b1;
        for (int i = 0; i < 40 && addr[0] < 8; i++) begin
            @(negedge clk);
            hsk = bus.o_req_ready[0] && valid[0];
            tick();
            if (hsk) addr[0]++;
        end
        valid = '0;
        chk("bp_stream_done", 64'(addr[0]), 64'h8);
        repeat (4) tick();
        chk("bp_drained", 64'(bus.o_busy), 64'h0);

        // Owner isolation: requester 1 stalls its response
        do_reset();
        rready  = 3'b101;
        valid   = 3'b010;
        addr[1] = 17'h20;
        addr[0] = 17'h40;
        nacc    = 0;
        @(negedge clk);
        if (|(bus.o_req_ready & valid)) nacc++;
        tick();
        valid = 3'b011;
        repeat (7) begin
            @(negedge clk);
            if (|(bus.o_req_ready & valid)) nacc++;
            chk("iso_resp_valid0", 64'(bus.o_resp_valid[0]), 64'h0);
            tick();
        end
        chk("iso_accepts", 64'(nacc), 64'h2);
        chk("iso_resp_owner", 64'(bus.o_resp_valid), 64'h2);
        rready = '1;
        valid  = '0;
        repeat (4) tick();

        // Wrap-around from the highest index
        do_reset();
        valid   = 3'b100;
        addr[2] = 17'h7;
        tick();
        valid   = 3'b101;
        addr[0] = 17'h5;
        @(negedge clk);
        chk("wrap_grant", 64'(bus.o_req_ready), 64'h1);
        tick();
        valid = '0;
        repeat (4) tick();

        // Asynchronous reset with reads in flight
        do_reset();
        valid   = 3'b001;
        addr[0] = 17'h33;
        tick();
        valid = '0;
        tick();
        nrst  = 1'b0;
        valid = 3'b111;
        #1;
        chk("mid_rst_ready", 64'(bus.o_req_ready), 64'h0);
        chk("mid_rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
        chk("mid_rst_rdata", bus.o_resp_rdata, 64'h0);
        chk("mid_rst_rom_addr", 64'(bus.o_rom_addr), 64'h0);
        chk("mid_rst_busy", 64'(bus.o_busy), 64'h0);
        tick();
        nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 64'(bus.o_req_ready), 64'h1);
        tick();
        valid = '0;
        repeat (4) tick();

        // Random traffic with occasional resets
        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            valid = NREQ'($urandom_range(0, 7));
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 3) == 0) addr[k] = ABITS'($urandom);
            end
            rready = NREQ'($urandom) | NREQ'($urandom);
            tick();
        end
        valid  = '0;
        rready = '1;
        repeat (5) tick();
        chk("final_idle", 64'(bus.o_busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
